// File: rtl/rtc_pkg.sv
// Shared constants, types and helpers for the adjustable time-of-day counter.
package rtc_pkg;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [5:0] HR_MAX  = 6'd23;

   localparam logic [5:0] CUR_SEC_U = 6'b000001;
   localparam logic [5:0] CUR_SEC_T = 6'b000010;
   localparam logic [5:0] CUR_MIN_U = 6'b000100;
   localparam logic [5:0] CUR_MIN_T = 6'b001000;
   localparam logic [5:0] CUR_HR_U  = 6'b010000;
   localparam logic [5:0] CUR_HR_T  = 6'b100000;

   localparam int BCD_SEC_U = 0;
   localparam int BCD_SEC_T = 4;
   localparam int BCD_MIN_U = 8;
   localparam int BCD_MIN_T = 12;
   localparam int BCD_HR_U  = 16;
   localparam int BCD_HR_T  = 20;

   typedef enum logic {MODE_RUN, MODE_ADJ} mode_e;

   // Add or subtract step, wrapping within 0..max with no carry out.
   function automatic logic [5:0] step_mod(input logic [5:0] val, input logic [5:0] step,
                                           input logic up, input logic [5:0] max);
      logic [6:0] s;
      if (up) begin
         s = {1'b0, val} + {1'b0, step};
         if (s > {1'b0, max}) s = s - ({1'b0, max} + 7'd1);
      end else if (val >= step) begin
         s = {1'b0, val} - {1'b0, step};
      end else begin
         s = {1'b0, val} + {1'b0, max} + 7'd1 - {1'b0, step};
      end
      return s[5:0];
   endfunction

endpackage

// File: rtl/bin2bcd60.sv
// Combinational 0..59 binary to two BCD digits.
module bin2bcd60 (
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units
);
   logic [5:0] base;

   always_comb begin
      tens = 4'd0;
      base = 6'd0;
      if (bin >= 6'd50) begin
         tens = 4'd5; base = 6'd50;
      end else if (bin >= 6'd40) begin
         tens = 4'd4; base = 6'd40;
      end else if (bin >= 6'd30) begin
         tens = 4'd3; base = 6'd30;
      end else if (bin >= 6'd20) begin
         tens = 4'd2; base = 6'd20;
      end else if (bin >= 6'd10) begin
         tens = 4'd1; base = 6'd10;
      end
      units = 4'(bin - base);
   end
endmodule

// File: rtl/adjustable_rtc.sv
// hh:mm:ss counter with tick prescaler, per-field adjust mode with idle timeout,
// and a registered BCD display stage with optional 12-hour rendering.
module adjustable_rtc
   import rtc_pkg::*;
#(
   parameter int TICK_DIV     = 100_000_000,
   parameter int EDIT_TIMEOUT = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        power_on,
   input  logic        adj_toggle,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        hour12,
   output logic [23:0] bcd_time,
   output logic        pm,
   output logic        adjust_active,
   output logic [5:0]  cursor,
   output logic        sec_pulse
);
   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int IDLE_W = (EDIT_TIMEOUT == 0) ? 1 : $clog2(EDIT_TIMEOUT + 1);

   logic [5:0]        sec_q, sec_d, min_q, min_d;
   logic [4:0]        hr_q, hr_d;
   logic [DIV_W-1:0]  pre_q, pre_d;
   logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
   mode_e             mode_q, mode_d;
   logic [5:0]        cur_q, cur_d;
   logic              pwr_q, sec_pulse_q, sec_pulse_d, pm_q, pm_d;
   logic [23:0]       bcd_q, bcd_d;

   logic       pwr_rise, pre_wrap, any_btn;
   logic [5:0] sec_step, min_step, hr_step, hr_disp;
   logic [3:0] sec_t, sec_u, min_t, min_u, hr_t, hr_u;

   assign pwr_rise = power_on & ~pwr_q;
   assign pre_wrap = (pre_q == DIV_W'(TICK_DIV - 1));
   assign any_btn  = btn_up | btn_down | btn_left | btn_right;
   assign idle_inc = idle_q + IDLE_W'(1);

   // Candidate edit results; only the field under the cursor is committed.
   assign sec_step = step_mod(sec_q, (cur_q == CUR_SEC_T) ? 6'd10 : 6'd1, btn_up, SEC_MAX);
   assign min_step = step_mod(min_q, (cur_q == CUR_MIN_T) ? 6'd10 : 6'd1, btn_up, MIN_MAX);
   assign hr_step  = step_mod({1'b0, hr_q}, (cur_q == CUR_HR_T) ? 6'd10 : 6'd1, btn_up, HR_MAX);

   always_comb begin
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      pre_d       = pre_q;
      idle_d      = idle_q;
      mode_d      = mode_q;
      cur_d       = cur_q;
      sec_pulse_d = 1'b0;
      if (pwr_rise) begin
         sec_d  = '0;
         min_d  = '0;
         hr_d   = '0;
         pre_d  = '0;
         idle_d = '0;
         mode_d = MODE_RUN;
         cur_d  = CUR_SEC_U;
      end else if (adj_toggle && power_on) begin
         mode_d = (mode_q == MODE_RUN) ? MODE_ADJ : MODE_RUN;
         pre_d  = '0;
         idle_d = '0;
      end else if (mode_q == MODE_ADJ) begin
         if (any_btn) begin
            pre_d  = '0;
            idle_d = '0;
            if (btn_up || btn_down) begin
               if (cur_q == CUR_SEC_U || cur_q == CUR_SEC_T) sec_d = sec_step;
               if (cur_q == CUR_MIN_U || cur_q == CUR_MIN_T) min_d = min_step;
               if (cur_q == CUR_HR_U  || cur_q == CUR_HR_T)  hr_d  = hr_step[4:0];
            end else if (btn_left) begin
               cur_d = {cur_q[4:0], cur_q[5]};
            end else begin
               cur_d = {cur_q[0], cur_q[5:1]};
            end
         end else if (pre_wrap) begin
            pre_d  = '0;
            idle_d = idle_inc;
            if (EDIT_TIMEOUT != 0 && idle_inc == IDLE_W'(EDIT_TIMEOUT)) begin
               mode_d = MODE_RUN;
               idle_d = '0;
            end
         end else begin
            pre_d = pre_q + DIV_W'(1);
         end
      end else if (pre_wrap) begin
         pre_d       = '0;
         sec_pulse_d = 1'b1;
         if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
               min_d = '0;
               hr_d  = (hr_q == HR_MAX[4:0]) ? 5'd0 : hr_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else begin
         pre_d = pre_q + DIV_W'(1);
      end
   end

   // Display hour: state is always 24-hour, 12-hour mode maps 0 -> 12 AM.
   always_comb begin
      hr_disp = {1'b0, hr_q};
      pm_d    = 1'b0;
      if (hour12) begin
         if (hr_q == 5'd0) begin
            hr_disp = 6'd12;
         end else if (hr_q >= 5'd12) begin
            pm_d = 1'b1;
            if (hr_q != 5'd12) hr_disp = {1'b0, hr_q} - 6'd12;
         end
      end
   end

   bin2bcd60 u_sec (.bin(sec_q),   .tens(sec_t), .units(sec_u));
   bin2bcd60 u_min (.bin(min_q),   .tens(min_t), .units(min_u));
   bin2bcd60 u_hr  (.bin(hr_disp), .tens(hr_t),  .units(hr_u));

   always_comb begin
      bcd_d = '0;
      bcd_d[BCD_SEC_U +: 4] = sec_u;
      bcd_d[BCD_SEC_T +: 4] = sec_t;
      bcd_d[BCD_MIN_U +: 4] = min_u;
      bcd_d[BCD_MIN_T +: 4] = min_t;
      bcd_d[BCD_HR_U  +: 4] = hr_u;
      bcd_d[BCD_HR_T  +: 4] = hr_t;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         pre_q       <= '0;
         idle_q      <= '0;
         mode_q      <= MODE_RUN;
         cur_q       <= CUR_SEC_U;
         pwr_q       <= 1'b0;
         sec_pulse_q <= 1'b0;
         bcd_q       <= '0;
         pm_q        <= 1'b0;
      end else begin
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         pre_q       <= pre_d;
         idle_q      <= idle_d;
         mode_q      <= mode_d;
         cur_q       <= cur_d;
         pwr_q       <= power_on;
         sec_pulse_q <= sec_pulse_d;
         bcd_q       <= bcd_d;
         pm_q        <= pm_d;
      end
   end

   assign bcd_time      = bcd_q;
   assign pm            = pm_q;
   assign adjust_active = (mode_q == MODE_ADJ);
   assign cursor        = cur_q;
   assign sec_pulse     = sec_pulse_q;

endmodule

// File: tb/tb_adjustable_rtc.sv
// Directed bench for adjustable_rtc with TICK_DIV=4, EDIT_TIMEOUT=3.
module tb_adjustable_rtc;
   logic        clk, rst, power_on, adj_toggle, btn_up, btn_down, btn_left, btn_right, hour12;
   logic [23:0] bcd_time;
   logic        pm, adjust_active, sec_pulse;
   logic [5:0]  cursor;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100, RT = 5'b01000, TG = 5'b10000;

   adjustable_rtc #(.TICK_DIV(4), .EDIT_TIMEOUT(3)) dut (
      .clk(clk), .rst(rst), .power_on(power_on), .adj_toggle(adj_toggle),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .hour12(hour12), .bcd_time(bcd_time), .pm(pm), .adjust_active(adjust_active),
      .cursor(cursor), .sec_pulse(sec_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [4:0] m, input int n);
      repeat (n) begin
         btn_up = m[0]; btn_down = m[1]; btn_left = m[2]; btn_right = m[3]; adj_toggle = m[4];
         @(negedge clk);
         btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; adj_toggle = 0;
      end
   endtask

   initial begin
      int npulse, last, gap_err, adj_pulses;
      rst = 1; power_on = 0; adj_toggle = 0; btn_up = 0; btn_down = 0;
      btn_left = 0; btn_right = 0; hour12 = 0;
      cyc(2);
      chk("rst_bcd", bcd_time, 24'h0);
      chk("rst_pm", 24'(pm), 24'h0);
      chk("rst_adj", 24'(adjust_active), 24'h0);
      chk("rst_cursor", 24'(cursor), 24'h1);
      chk("rst_pulse", 24'(sec_pulse), 24'h0);
      rst = 0;

      // 1: run 61 seconds from power-up
      power_on = 1;
      npulse = 0; last = 0; gap_err = 0;
      for (int i = 1; i <= 246; i++) begin
         @(negedge clk);
         if (sec_pulse) begin
            if (last != 0 && i - last != 4) gap_err++;
            if (last == 0 && i != 5) gap_err++;
            last = i;
            npulse++;
         end
      end
      chk("run_61s_bcd", bcd_time, 24'h000101);
      chk("run_61s_pulses", 24'(npulse), 24'd61);
      chk("run_pulse_spacing", 24'(gap_err), 24'd0);

      // 2: preload 23:59:59 then roll over
      press(TG, 1);
      chk("adj_enter", 24'(adjust_active), 24'h1);
      press(DN, 2); press(LT, 2); press(DN, 2); press(LT, 2); press(DN, 1);
      cyc(1);
      chk("preload_bcd", bcd_time, 24'h235959);
      chk("preload_cursor", 24'(cursor), 24'h10);
      press(TG, 1);
      cyc(4);
      chk("rollover_pulse", 24'(sec_pulse), 24'h1);
      chk("rollover_bcd_lag", bcd_time, 24'h235959);
      cyc(1);
      chk("rollover_bcd", bcd_time, 24'h000000);
      chk("rollover_pulse_end", 24'(sec_pulse), 24'h0);

      // 3: per-field edits without carry, cursor wrap, button priority
      press(TG, 1);
      press(RT, 3); press(UP, 5); press(RT, 1); press(UP, 5); press(LT, 1);
      press(UP, 1);
      cyc(1);
      chk("sec55_plus10", bcd_time, 24'h000005);
      press(LT, 4); press(UP, 1); press(RT, 1); press(UP, 8); press(LT, 1);
      press(UP, 1);
      cyc(1);
      chk("hr18_plus10", bcd_time, 24'h040005);
      chk("cursor_hr_t", 24'(cursor), 24'h20);
      press(LT, 1);
      chk("cursor_wrap_left", 24'(cursor), 24'h01);
      press(UP | DN | LT, 1);
      cyc(1);
      chk("prio_up_bcd", bcd_time, 24'h040006);
      chk("prio_up_cursor", 24'(cursor), 24'h01);
      press(RT, 1);
      chk("cursor_wrap_right", 24'(cursor), 24'h20);
      press(DN, 1);
      press(RT, 4); press(DN, 1);
      cyc(1);
      chk("hr04_sec06_minus10", bcd_time, 24'h180056);

      // 4: idle timeout, restarted by a button at cycle 10
      adj_pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sec_pulse) adj_pulses++;
      end
      press(LT, 1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (sec_pulse) adj_pulses++;
      end
      chk("timeout_restarted", 24'(adjust_active), 24'h1);
      cyc(1);
      chk("timeout_exit", 24'(adjust_active), 24'h0);
      chk("adj_no_pulse", 24'(adj_pulses), 24'd0);
      chk("adj_time_frozen", bcd_time, 24'h180056);
      cyc(5);
      chk("resume_after_timeout", bcd_time, 24'h180057);

      // 5: 12-hour display
      press(TG, 1);
      press(LT, 2); press(UP, 6);
      hour12 = 1;
      cyc(1);
      chk("h12_hr0_bcd", bcd_time, 24'h120057);
      chk("h12_hr0_pm", 24'(pm), 24'h0);
      press(LT, 1); press(UP, 1); press(RT, 1); press(UP, 2);
      cyc(1);
      chk("h12_hr12_bcd", bcd_time, 24'h120057);
      chk("h12_hr12_pm", 24'(pm), 24'h1);
      press(UP, 1);
      cyc(1);
      chk("h12_hr13_bcd", bcd_time, 24'h010057);
      chk("h12_hr13_pm", 24'(pm), 24'h1);
      hour12 = 0;
      cyc(1);
      chk("h24_hr13_bcd", bcd_time, 24'h130057);
      chk("h24_hr13_pm", 24'(pm), 24'h0);

      // 6: power cycle clears time, overrides same-cycle buttons; then rst
      power_on = 0;
      cyc(1);
      power_on = 1;
      cyc(1);
      chk("pwr_exit_adj", 24'(adjust_active), 24'h0);
      chk("pwr_cursor", 24'(cursor), 24'h01);
      cyc(29);
      chk("run_7s", bcd_time, 24'h000007);
      power_on = 0;
      cyc(1);
      power_on = 1;
      press(UP | TG, 1);
      chk("pwr_ignores_toggle", 24'(adjust_active), 24'h0);
      chk("pwr_cursor2", 24'(cursor), 24'h01);
      cyc(1);
      chk("pwr_clear_bcd", bcd_time, 24'h000000);
      press(TG, 1); press(LT, 1); press(UP, 1);
      hour12 = 1;
      cyc(1);
      chk("pre_rst_bcd", bcd_time, 24'h120010);
      chk("pre_rst_cursor", 24'(cursor), 24'h02);
      rst = 1;
      cyc(1);
      chk("mid_rst_bcd", bcd_time, 24'h0);
      chk("mid_rst_pm", 24'(pm), 24'h0);
      chk("mid_rst_adj", 24'(adjust_active), 24'h0);
      chk("mid_rst_cursor", 24'(cursor), 24'h01);
      chk("mid_rst_pulse", 24'(sec_pulse), 24'h0);
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
